// File: rtl/dm_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter: lock owner encoding,
// the in-flight read tag, and default geometry.
package dm_arb_pkg;

  localparam int DM_AW       = 8;
  localparam int DM_DW       = 8;
  localparam int DM_MAX_HOLD = 16;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_t;

  typedef struct packed {
    logic valid;
    logic master;
  } rd_tag_t;

  function automatic owner_t owner_of(input logic master);
    return master ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/dm_arb_rr_pick.sv
// Combinational two-way picker: a locked owner keeps priority until its hold
// limit is reached while the other side waits, otherwise round-robin on last.
module dm_arb_rr_pick
  import dm_arb_pkg::*;
(
  input  logic   i_req0,
  input  logic   i_req1,
  input  owner_t i_owner,
  input  logic   i_hold_max,
  input  logic   i_last,
  output logic   o_gnt0,
  output logic   o_gnt1
);

  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if ((i_owner == OWN_M0) && i_req0 && !(i_hold_max && i_req1)) begin
      o_gnt0 = 1'b1;
    end else if ((i_owner == OWN_M1) && i_req1 && !(i_hold_max && i_req0)) begin
      o_gnt1 = 1'b1;
    end else if (i_req0 && i_req1) begin
      // Owner of a forced hand-off is always last, so this hands over.
      o_gnt0 = i_last;
      o_gnt1 = !i_last;
    end else if (i_req0) begin
      o_gnt0 = 1'b1;
    end else if (i_req1) begin
      o_gnt1 = 1'b1;
    end else begin
      o_gnt0 = 1'b0;
      o_gnt1 = 1'b0;
    end
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-master arbiter in front of the single-port data memory, with bus lock and
// read-return routing. Define DM_ARBITER_STATS_EN to add saturating usage counters.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW       = DM_AW,
  parameter int DW       = DM_DW,
  parameter int MAX_HOLD = DM_MAX_HOLD
) (
  input  logic          clk,
  input  logic          init,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic          m0_lock,
  input  logic          m1_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_gnt,
  output logic          m1_gnt,
  output logic          m0_rvalid,
  output logic          m1_rvalid,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
`ifdef DM_ARBITER_STATS_EN
  output logic [15:0]   stat_m0_cnt,
  output logic [15:0]   stat_m1_cnt,
  output logic [15:0]   stat_conflict_cnt,
`endif
  input  logic [DW-1:0] mem_rdata
);

  localparam int HW = $clog2(MAX_HOLD + 1);

  owner_t        r_owner;
  logic          r_last;
  logic [HW-1:0] r_hold_cnt;
  rd_tag_t       r_rd_tag;

  logic w_pick0, w_pick1, w_acc, w_hold_max, w_sel_lock, w_sel_we;
  logic w_gnt0, w_gnt1;

  assign w_hold_max = (r_hold_cnt == HW'(MAX_HOLD));

  dm_arb_rr_pick u_pick (
    .i_req0    (m0_req),
    .i_req1    (m1_req),
    .i_owner   (r_owner),
    .i_hold_max(w_hold_max),
    .i_last    (r_last),
    .o_gnt0    (w_pick0),
    .o_gnt1    (w_pick1)
  );

  // State updates use the raw pick; init only masks the visible outputs.
  assign w_acc      = w_pick0 | w_pick1;
  assign w_sel_lock = w_pick1 ? m1_lock : m0_lock;
  assign w_sel_we   = w_pick1 ? m1_we : m0_we;

  assign w_gnt0 = w_pick0 & ~init;
  assign w_gnt1 = w_pick1 & ~init;
  assign m0_gnt = w_gnt0;
  assign m1_gnt = w_gnt1;

  always_comb begin
    mem_en    = w_gnt0 | w_gnt1;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_gnt0) begin
      mem_we    = m0_we;
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
    end else if (w_gnt1) begin
      mem_we    = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      r_last     <= 1'b1;
      r_owner    <= OWN_NONE;
      r_hold_cnt <= '0;
      r_rd_tag   <= '0;
    end else if (w_acc) begin
      r_last <= w_pick1;
      if (w_sel_lock) begin
        r_owner <= owner_of(w_pick1);
        if (r_owner == owner_of(w_pick1)) begin
          r_hold_cnt <= w_hold_max ? r_hold_cnt : r_hold_cnt + HW'(1);
        end else begin
          r_hold_cnt <= HW'(1);
        end
      end else begin
        r_owner    <= OWN_NONE;
        r_hold_cnt <= '0;
      end
      r_rd_tag <= '{valid: !w_sel_we, master: w_pick1};
    end else begin
      if (((r_owner == OWN_M0) && !m0_req) || ((r_owner == OWN_M1) && !m1_req)) begin
        r_owner <= OWN_NONE;
      end else begin
        r_owner <= r_owner;
      end
      r_hold_cnt <= '0;
      r_rd_tag   <= '0;
    end
  end

  assign m0_rvalid = r_rd_tag.valid && !r_rd_tag.master;
  assign m1_rvalid = r_rd_tag.valid && r_rd_tag.master;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

`ifdef DM_ARBITER_STATS_EN
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      stat_m0_cnt       <= 16'd0;
      stat_m1_cnt       <= 16'd0;
      stat_conflict_cnt <= 16'd0;
    end else begin
      if (w_pick0 && (stat_m0_cnt != 16'hFFFF)) stat_m0_cnt <= stat_m0_cnt + 16'd1;
      if (w_pick1 && (stat_m1_cnt != 16'hFFFF)) stat_m1_cnt <= stat_m1_cnt + 16'd1;
      if (m0_req && m1_req && (stat_conflict_cnt != 16'hFFFF))
        stat_conflict_cnt <= stat_conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: expected read returns go into a scoreboard queue
// that a negedge monitor drains; grants and mux outputs are checked inline.
module tb_dm_arbiter;

  logic       clk = 1'b0;
  logic       init;
  logic       m0_req, m1_req, m0_we, m1_we, m0_lock, m1_lock;
  logic [7:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic       m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [7:0] m0_rdata, m1_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DM_ARBITER_STATS_EN
  logic [15:0] stat_m0_cnt, stat_m1_cnt, stat_conflict_cnt;
`endif

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .init(init),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_lock(m0_lock), .m1_lock(m1_lock), .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata), .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
`ifdef DM_ARBITER_STATS_EN
    .stat_m0_cnt(stat_m0_cnt), .stat_m1_cnt(stat_m1_cnt), .stat_conflict_cnt(stat_conflict_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  // Data memory model: preloaded with addr^0x85, write visible to the next read.
  logic [7:0] mem [0:255];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h85;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  function automatic logic [7:0] pre(input logic [7:0] a);
    return a ^ 8'h85;
  endfunction

  typedef struct packed {logic master; logic [7:0] data;} exp_t;
  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_gnt(input string nm, input logic [1:0] exp_g, input logic [7:0] exp_a);
    chk({nm, "_gnt"}, 32'({m1_gnt, m0_gnt}), 32'(exp_g));
    chk({nm, "_addr"}, 32'(mem_addr), 32'(exp_a));
  endtask

  task automatic push(input logic master, input logic [7:0] data);
    exp_t e;
    e.master = master;
    e.data   = data;
    sb_q.push_back(e);
  endtask

  // Monitor: every read return must match the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (m0_rvalid || m1_rvalid) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
        end else begin
          e = sb_q.pop_front();
          chk("rvalid_master", 32'({m1_rvalid, m0_rvalid}), e.master ? 32'h2 : 32'h1);
          chk("rdata", 32'(e.master ? m1_rdata : m0_rdata), 32'(e.data));
          chk("other_rdata", 32'(e.master ? m0_rdata : m1_rdata), 32'h0);
        end
      end
    end
  end

  initial begin
    int p;
    logic m0_done;
    init = 1'b1;
    m0_req = 1'b1; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_lock = 1'b0; m1_lock = 1'b0;
    m0_addr = 8'h40; m1_addr = 8'h00; m0_wdata = 8'h11; m1_wdata = 8'h00;

    // Reset: outputs masked even with a request pending.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);

    // Single m0 read of 0x40.
    @(negedge clk);
    init = 1'b0;
    #1;
    chk_gnt("t1", 2'b01, 8'h40);
    chk("t1_we", 32'(mem_we), 32'h0);
    push(1'b0, 8'hC5);
    @(negedge clk);
    m0_req = 1'b0;
    @(negedge clk);

    // Both requesting, no lock: m0,m1,m0,m1 after reset.
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 8'h01; m1_addr = 8'h02;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i % 2 == 0) begin
        chk_gnt("t2_alt", 2'b01, 8'h01);
        push(1'b0, pre(8'h01));
      end else begin
        chk_gnt("t2_alt", 2'b10, 8'h02);
        push(1'b1, pre(8'h02));
      end
      @(negedge clk);
    end
    m0_req = 1'b0; m1_req = 1'b0;
`ifdef DM_ARBITER_STATS_EN
    chk("t2_conflicts", 32'(stat_conflict_cnt), 32'd4);
    chk("t2_m0_cnt", 32'(stat_m0_cnt), 32'd2);
    chk("t2_m1_cnt", 32'(stat_m1_cnt), 32'd2);
`endif
    @(negedge clk);

    // m1 locked burst from 64; m0 waits from cycle 2 and gets in on cycle 16.
    p = 64;
    m0_done = 1'b0;
    m0_addr = 8'h10;
    for (int c = 0; c < 22; c++) begin
      m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 8'(p);
      m0_req = (c >= 2) && !m0_done;
      #1;
      if (c == 16) begin
        chk_gnt("t3_handoff", 2'b01, 8'h10);
        push(1'b0, pre(8'h10));
        m0_done = 1'b1;
      end else begin
        chk_gnt("t3_burst", 2'b10, 8'(p));
        push(1'b1, pre(8'(p)));
        p++;
      end
      @(negedge clk);
    end
    m1_req = 1'b0; m1_lock = 1'b0; m0_req = 1'b0;
    @(negedge clk);

    // Write 0x4D to addr 0, then read it back next cycle.
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h00; m0_wdata = 8'h4D;
    #1;
    chk_gnt("t4_wr", 2'b01, 8'h00);
    chk("t4_mem_we", 32'(mem_we), 32'h1);
    chk("t4_mem_wdata", 32'(mem_wdata), 32'h4D);
    @(negedge clk);
    m0_we = 1'b0;
    #1;
    chk_gnt("t4_rd", 2'b01, 8'h00);
    chk("t4_rd_we", 32'(mem_we), 32'h0);
    push(1'b0, 8'h4D);
    @(negedge clk);
    m0_req = 1'b0;
    @(negedge clk);

    // init while an m1 locked read is in flight.
    m1_req = 1'b1; m1_lock = 1'b1; m1_addr = 8'h70;
    #1;
    chk_gnt("t5_m1", 2'b10, 8'h70);
    @(posedge clk);
    #1;
    chk("t5_rvalid_pre", 32'(m1_rvalid), 32'h1);
    chk("t5_rdata_pre", 32'(m1_rdata), 32'(pre(8'h70)));
    init = 1'b1;
    #1;
    chk("t5_rvalid_drop", 32'(m1_rvalid), 32'h0);
    chk("t5_rdata_drop", 32'(m1_rdata), 32'h0);
    chk("t5_gnt_init", 32'({m1_gnt, m0_gnt}), 32'h0);
    chk("t5_en_init", 32'(mem_en), 32'h0);
    @(negedge clk);
    @(negedge clk);
    init = 1'b0;
    m0_req = 1'b1; m0_addr = 8'h20; m1_addr = 8'h71;
    #1;
    chk_gnt("t5_after", 2'b01, 8'h20);
    push(1'b0, pre(8'h20));
    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0; m1_lock = 1'b0;
    @(negedge clk);

    // Idle bus.
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_gnt", 32'({m1_gnt, m0_gnt}), 32'h0);
      chk("idle_en", 32'(mem_en), 32'h0);
      chk("idle_addr", 32'(mem_addr), 32'h0);
      chk("idle_rvalid", 32'({m1_rvalid, m0_rvalid}), 32'h0);
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
